filt_cic_comp: RTL and testbench

- Symmetric FIR CIC-compensation filter at the low input rate.
- Sits directly upstream of filt_cici and feeds it one sample per low-rate strobe.
- Pre-distorts the passband to cancel the CIC sinc droop.
- Time-multiplexed single-multiplier architecture: pre-adder exploits coefficient symmetry; one MAC per coefficient pair per cycle.

---
 rtl/filt_cic_comp.sv | 174 +++++++++++++++++
 tb/tb_filt_cic_comp.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/filt_cic_comp.sv
// filt_cic_comp: symmetric FIR CIC-compensation filter, low input rate.
// Time-multiplexed single multiplier: a pre-adder folds each symmetric tap pair,
// so a gp_taps filter needs K = (gp_taps+1)/2 MAC cycles per output sample.
// Optional build macro FILT_CIC_COMP_SAT_EN: when defined, the rounded result
// saturates to the gp_oup_width range; otherwise it wraps (low bits kept).
module filt_cic_comp #(
    parameter int unsigned gp_inp_width  = 16,
    parameter int unsigned gp_oup_width  = 16,
    parameter int unsigned gp_coef_width = 16,
    parameter int unsigned gp_coef_frac  = 14,
    parameter int unsigned gp_taps       = 5,
    parameter logic [((gp_taps+1)/2)*gp_coef_width-1:0] gp_coefs =
        {16'hFC00, 16'h0800, 16'h4000}
) (
    input  logic                    i_clk,
    input  logic                    i_rst_an,
    input  logic                    i_ena,
    input  logic                    i_vld,
    input  logic [gp_inp_width-1:0] i_data,
    output logic [gp_oup_width-1:0] o_data,
    output logic                    o_vld,
    output logic                    o_busy
);

    localparam int unsigned lp_k      = (gp_taps + 1) / 2;
    localparam int unsigned lp_kw     = $clog2(lp_k);
    localparam int unsigned lp_pw     = $clog2(gp_taps);
    localparam int unsigned lp_pre_w  = gp_inp_width + 1;
    localparam int unsigned lp_prod_w = lp_pre_w + gp_coef_width;
    localparam int unsigned lp_acc_w  = lp_prod_w + $clog2(lp_k);
    localparam int unsigned lp_rnd_w  = lp_acc_w + 1;
    localparam int unsigned lp_y_w    = lp_rnd_w - gp_coef_frac;

    localparam logic signed [lp_rnd_w-1:0] lp_half = lp_rnd_w'(1) << (gp_coef_frac - 1);

    typedef enum logic [1:0] {StIdle, StMac, StRound} t_state;

    t_state                         r_state;
    logic signed [gp_inp_width-1:0] r_dline [gp_taps];
    logic [lp_pw-1:0]               r_wptr;
    logic [lp_pw-1:0]               r_rd_a;   // walks from newest sample backwards
    logic [lp_pw-1:0]               r_rd_b;   // walks from oldest sample forwards
    logic [lp_kw-1:0]               r_k;
    logic signed [lp_acc_w-1:0]     r_acc;
    logic [gp_oup_width-1:0]        r_data;
    logic                           r_vld;
    logic                           r_busy;

    logic                           w_last;
    logic signed [gp_coef_width-1:0] w_coef;
    logic signed [gp_inp_width-1:0] w_a;
    logic signed [gp_inp_width-1:0] w_b;
    logic signed [lp_pre_w-1:0]     w_pre;
    logic signed [lp_prod_w-1:0]    w_prod;
    logic signed [lp_acc_w-1:0]     w_acc_nxt;
    logic signed [lp_rnd_w-1:0]     w_rnd;
    logic [gp_oup_width-1:0]        w_out;

    function automatic logic [lp_pw-1:0] f_inc(input logic [lp_pw-1:0] p);
        return (p == lp_pw'(gp_taps - 1)) ? '0 : p + lp_pw'(1);
    endfunction

    function automatic logic [lp_pw-1:0] f_dec(input logic [lp_pw-1:0] p);
        return (p == '0) ? lp_pw'(gp_taps - 1) : p - lp_pw'(1);
    endfunction

    // Coefficient select: c0 sits in the most significant slice of gp_coefs.
    always_comb begin
        w_coef = '0;
        for (int i = 0; i < int'(lp_k); i++) begin
            if (r_k == lp_kw'(i)) begin
                w_coef = gp_coefs[(int'(lp_k) - 1 - i) * int'(gp_coef_width) +: gp_coef_width];
            end
        end
    end

    // Pre-add of the symmetric tap pair; the centre tap has no partner.
    always_comb begin
        w_last    = (r_k == lp_kw'(lp_k - 1));
        w_a       = r_dline[r_rd_a];
        w_b       = w_last ? '0 : r_dline[r_rd_b];
        w_pre     = {w_a[gp_inp_width-1], w_a} + {w_b[gp_inp_width-1], w_b};
        w_prod    = w_pre * w_coef;
        w_acc_nxt = r_acc + {{(lp_acc_w - lp_prod_w){w_prod[lp_prod_w-1]}}, w_prod};
    end

`ifdef FILT_CIC_COMP_SAT_EN
    localparam logic signed [lp_y_w-1:0] lp_max =
        {{(lp_y_w - gp_oup_width + 1){1'b0}}, {(gp_oup_width - 1){1'b1}}};
    localparam logic signed [lp_y_w-1:0] lp_min =
        {{(lp_y_w - gp_oup_width + 1){1'b1}}, {(gp_oup_width - 1){1'b0}}};

    logic signed [lp_y_w-1:0] w_y;

    // Round half up, then clamp to the output range.
    always_comb begin
        w_rnd = {r_acc[lp_acc_w-1], r_acc} + lp_half;
        w_y   = lp_y_w'(w_rnd >>> gp_coef_frac);
        if (w_y > lp_max) begin
            w_out = lp_max[gp_oup_width-1:0];
        end else if (w_y < lp_min) begin
            w_out = lp_min[gp_oup_width-1:0];
        end else begin
            w_out = w_y[gp_oup_width-1:0];
        end
    end
`else
    // Round half up, then keep the low output bits (two's-complement wrap).
    always_comb begin
        w_rnd = {r_acc[lp_acc_w-1], r_acc} + lp_half;
        w_out = gp_oup_width'(w_rnd >>> gp_coef_frac);
    end
`endif

    // Control FSM, delay line, accumulator and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            r_state <= StIdle;
            for (int i = 0; i < int'(gp_taps); i++) begin
                r_dline[i] <= '0;
            end
            r_wptr <= '0;
            r_rd_a <= '0;
            r_rd_b <= '0;
            r_k    <= '0;
            r_acc  <= '0;
            r_data <= '0;
            r_vld  <= 1'b0;
            r_busy <= 1'b0;
        end else if (i_ena) begin
            r_vld <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_vld) begin
                        r_dline[r_wptr] <= i_data;
                        r_wptr          <= f_inc(r_wptr);
                        // Newest lands at r_wptr; the oldest is the next slot to overwrite.
                        r_rd_a          <= r_wptr;
                        r_rd_b          <= f_inc(r_wptr);
                        r_acc           <= '0;
                        r_k             <= '0;
                        r_busy          <= 1'b1;
                        r_state         <= StMac;
                    end
                end
                StMac: begin
                    r_acc  <= w_acc_nxt;
                    r_rd_a <= f_dec(r_rd_a);
                    r_rd_b <= f_inc(r_rd_b);
                    r_k    <= r_k + lp_kw'(1);
                    if (w_last) begin
                        r_state <= StRound;
                    end
                end
                StRound: begin
                    r_data  <= w_out;
                    r_vld   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end else begin
            r_vld <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_vld  = r_vld & i_ena;
    assign o_busy = r_busy;

endmodule

// File: tb/tb_filt_cic_comp.sv
// Directed bench for filt_cic_comp: 5 taps, c = {-1024, 2048, 16384}, frac 14.
module tb_filt_cic_comp;

    logic               clk    = 1'b0;
    logic               rst_an = 1'b1;
    logic               ena    = 1'b1;
    logic               vld    = 1'b0;
    logic signed [15:0] din    = '0;
    logic [15:0]        dout;
    logic               ovld;
    logic               busy;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef FILT_CIC_COMP_SAT_EN
    localparam int OvfP = 32767;
    localparam int OvfN = -32768;
`else
    // 32767 * 1.125 = 36862.875 -> rounds to 36863 -> wraps to -28673.
    localparam int OvfP = -28673;
    // -32768 * 1.125 = -36864 exactly -> wraps to 28672.
    localparam int OvfN = 28672;
`endif

    localparam int Imp [6] = '{-512, 1024, 8192, 1024, -512, 0};

    typedef struct {
        string              name;
        bit                 rst;
        logic signed [15:0] din;
        int                 exp;
        bit                 chk;
    } vec_t;

    vec_t tbl [$];

    always #5 clk = ~clk;

    filt_cic_comp #(
        .gp_inp_width (16),
        .gp_oup_width (16),
        .gp_coef_width(16),
        .gp_coef_frac (14),
        .gp_taps      (5),
        .gp_coefs     ({16'hFC00, 16'h0800, 16'h4000})
    ) dut (
        .i_clk   (clk),
        .i_rst_an(rst_an),
        .i_ena   (ena),
        .i_vld   (vld),
        .i_data  (din),
        .o_data  (dout),
        .o_vld   (ovld),
        .o_busy  (busy)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input bit r, input int d, input int e, input bit c);
        vec_t v;
        v.name = nm;
        v.rst  = r;
        v.din  = 16'(d);
        v.exp  = e;
        v.chk  = c;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_an = 1'b0;
        vld    = 1'b0;
        ena    = 1'b1;
        repeat (2) @(negedge clk);
        rst_an = 1'b1;
    endtask

    // Strobe one sample, then watch win edges for o_vld (latency counted in edges).
    task automatic send(input int d, input int win, output int lat, output int val,
                        output int pulses);
        @(negedge clk);
        vld = 1'b1;
        din = 16'(d);
        @(posedge clk);
        #1 vld = 1'b0;
        lat    = -1;
        val    = 0;
        pulses = 0;
        for (int c = 1; c <= win; c++) begin
            @(posedge clk);
            #1;
            if (ovld) begin
                pulses++;
                if (lat < 0) begin
                    lat = c;
                    val = int'($signed(dout));
                end
            end
        end
    endtask

    task automatic run_impulse(input string nm, input int first);
        int lat, val, p;
        for (int i = first; i < 6; i++) begin
            send((i == 0) ? 8192 : 0, 7, lat, val, p);
            chk($sformatf("%s lat[%0d]", nm, i), lat, 4);
            chk($sformatf("%s val[%0d]", nm, i), val, Imp[i]);
        end
    endtask

    initial begin
        int lat, val, p, first;

        add("imp", 1, 8192, -512, 1);
        add("imp", 0, 0, 1024, 1);
        add("imp", 0, 0, 8192, 1);
        add("imp", 0, 0, 1024, 1);
        add("imp", 0, 0, -512, 1);
        add("imp", 0, 0, 0, 1);
        add("dcp", 1, 1000, -62, 1);
        add("dcp", 0, 1000, 63, 1);
        add("dcp", 0, 1000, 1063, 1);
        add("dcp", 0, 1000, 1188, 1);
        add("dcp", 0, 1000, 1125, 1);
        add("dcp", 0, 1000, 1125, 1);
        add("dcn", 1, -1000, 63, 1);
        add("dcn", 0, -1000, -62, 1);
        add("dcn", 0, -1000, -1062, 1);
        add("dcn", 0, -1000, -1187, 1);
        add("dcn", 0, -1000, -1125, 1);
        add("dcn", 0, -1000, -1125, 1);
        for (int i = 0; i < 4; i++) add("ovp", (i == 0), 32767, 0, 0);
        add("ovp", 0, 32767, OvfP, 1);
        add("ovp", 0, 32767, OvfP, 1);
        for (int i = 0; i < 4; i++) add("ovn", (i == 0), -32768, 0, 0);
        add("ovn", 0, -32768, OvfN, 1);
        add("ovn", 0, -32768, OvfN, 1);

        // Reset state
        #2 rst_an = 1'b0;
        #1;
        chk("rst o_data", int'(dout), 0);
        chk("rst o_vld", int'(ovld), 0);
        chk("rst o_busy", int'(busy), 0);
        @(negedge clk);
        rst_an = 1'b1;

        // Table-driven vectors
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            send(int'(tbl[i].din), 7, lat, val, p);
            chk($sformatf("%s[%0d] lat", tbl[i].name, i), lat, 4);
            if (tbl[i].chk) chk($sformatf("%s[%0d] val", tbl[i].name, i), val, tbl[i].exp);
        end

        // Busy drop: extra strobes during MAC (edge 2) and ROUND (edge 4) are ignored
        do_reset();
        @(negedge clk);
        vld = 1'b1;
        din = 16'sd8192;
        @(posedge clk);
        #1 vld = 1'b0;
        chk("busy after accept", int'(busy), 1);
        lat = -1;
        val = 0;
        p   = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            vld = (c == 2) || (c == 4);
            din = (c == 2) ? 16'sd5000 : 16'sd7000;
            @(posedge clk);
            #1 vld = 1'b0;
            if (c == 3) chk("busy in round", int'(busy), 1);
            if (c == 4) chk("busy after round", int'(busy), 0);
            if (ovld) begin
                p++;
                if (lat < 0) begin
                    lat = c;
                    val = int'($signed(dout));
                end
            end
        end
        chk("drop pulses", p, 1);
        chk("drop lat", lat, 4);
        chk("drop val", val, -512);
        run_impulse("drop tail", 1);

        // Reset mid-MAC aborts; following impulse response matches a fresh reset
        do_reset();
        send(3000, 7, lat, val, p);
        chk("pre-abort val", val, -187);
        @(negedge clk);
        vld = 1'b1;
        din = 16'sd8192;
        @(posedge clk);
        #1 vld = 1'b0;
        @(posedge clk);
        #1 rst_an = 1'b0;
        #1;
        chk("abort o_data", int'(dout), 0);
        chk("abort o_busy", int'(busy), 0);
        chk("abort o_vld", int'(ovld), 0);
        @(negedge clk);
        rst_an = 1'b1;
        p = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (ovld) p++;
        end
        chk("abort pulses", p, 0);
        first = 0;
        run_impulse("post-abort", first);

        // Enable low for 3 cycles mid-MAC delays o_vld by exactly 3
        do_reset();
        @(negedge clk);
        vld = 1'b1;
        din = 16'sd8192;
        @(posedge clk);
        #1 vld = 1'b0;
        lat = -1;
        val = 0;
        p   = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            ena = !((c >= 2) && (c <= 4));
            @(posedge clk);
            #1;
            if (ovld) begin
                p++;
                if (lat < 0) begin
                    lat = c;
                    val = int'($signed(dout));
                end
            end
        end
        ena = 1'b1;
        chk("ena pulses", p, 1);
        chk("ena lat", lat, 7);
        chk("ena val", val, -512);
        run_impulse("ena tail", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
